// File: rtl/score_recorder.sv
// Score recorder: turns a stream of held piano keys and duration ticks into
// {note, length} entries written to an external score memory. A take runs
// ARMED -> TRACK/WRITE -> DONE; rests (no key held) are recorded as note 31.
module score_recorder #(
  parameter int audio_len = 6,
  parameter int len_w     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rec_start,
  input  logic                 rec_stop,
  input  logic                 key_valid,
  input  logic [4:0]           key_note,
  input  logic                 tick,
  output logic                 wr_en,
  output logic [audio_len-1:0] wr_addr,
  output logic [len_w+4:0]     wr_data,
  output logic [audio_len:0]   rec_count,
  output logic                 busy,
  output logic                 Done_record
);

  localparam int CNT_W = audio_len + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_TRACK = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [4:0]           REST_NOTE = 5'd31;
  localparam logic [len_w-1:0]     LEN_MAX   = '1;
  localparam logic [audio_len-1:0] ADDR_MAX  = '1;

  logic [2:0]           state_reg, state_next;
  logic [4:0]           cur_note_reg, cur_note_next;
  logic [len_w-1:0]     len_reg, len_next;
  logic                 stop_pending_reg, stop_pending_next;
  logic                 wr_en_reg, wr_en_next;
  logic [audio_len-1:0] wr_addr_reg, wr_addr_next;
  logic [len_w+4:0]     wr_data_reg, wr_data_next;
  logic [audio_len:0]   rec_count_reg, rec_count_next;

  logic [4:0]           eff_note;
  logic                 len_sat;
  logic [len_w-1:0]     close_len;

  // Effective note and the length a segment would carry if it closed this
  // cycle. A tick coinciding with a close is credited to the closing segment
  // unless that segment is already saturated.
  always_comb begin
    eff_note  = key_valid ? key_note : REST_NOTE;
    len_sat   = (len_reg == LEN_MAX);
    close_len = (tick && !len_sat) ? (len_reg + len_w'(1)) : len_reg;
  end

  // Next-state and datapath decisions for the recording FSM.
  always_comb begin
    state_next        = state_reg;
    cur_note_next     = cur_note_reg;
    len_next          = len_reg;
    stop_pending_next = stop_pending_reg;
    wr_en_next        = 1'b0;
    wr_addr_next      = wr_addr_reg;
    wr_data_next      = wr_data_reg;
    rec_count_next    = rec_count_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        // A simultaneous stop cancels the start request.
        if (rec_start && !rec_stop) begin
          state_next        = S_ARMED;
          wr_addr_next      = '0;
          rec_count_next    = '0;
          cur_note_next     = REST_NOTE;
          len_next          = '0;
          stop_pending_next = 1'b0;
        end
      end

      S_ARMED: begin
        // Leading silence is skipped: the take starts on the first key.
        if (rec_stop) begin
          state_next = S_DONE;
        end else if (key_valid) begin
          state_next    = S_TRACK;
          cur_note_next = key_note;
          len_next      = '0;
        end
      end

      S_TRACK: begin
        if (rec_stop) begin
          // Flush the open segment (rests included), then finish the take.
          if (close_len != '0) begin
            state_next        = S_WRITE;
            wr_en_next        = 1'b1;
            wr_data_next      = {cur_note_reg, close_len};
            stop_pending_next = 1'b1;
            len_next          = '0;
          end else begin
            state_next = S_DONE;
          end
        end else if (eff_note != cur_note_reg) begin
          // Change-close; a zero-length segment is a glitch and is dropped.
          cur_note_next = eff_note;
          len_next      = (tick && len_sat) ? len_w'(1) : '0;
          if (close_len != '0) begin
            state_next   = S_WRITE;
            wr_en_next   = 1'b1;
            wr_data_next = {cur_note_reg, close_len};
          end
        end else if (tick && len_sat) begin
          // Saturation-close: the note continues in a fresh segment.
          state_next   = S_WRITE;
          wr_en_next   = 1'b1;
          wr_data_next = {cur_note_reg, LEN_MAX};
          len_next     = len_w'(1);
        end else if (tick) begin
          len_next = len_reg + len_w'(1);
        end
      end

      S_WRITE: begin
        // Ticks keep counting for the segment that is already open.
        if (tick && !len_sat) begin
          len_next = len_reg + len_w'(1);
        end
        rec_count_next = rec_count_reg + CNT_W'(1);
        if (wr_addr_reg != ADDR_MAX) begin
          wr_addr_next = wr_addr_reg + audio_len'(1);
        end
        if ((wr_addr_reg == ADDR_MAX) || stop_pending_reg || rec_stop) begin
          state_next        = S_DONE;
          stop_pending_next = 1'b0;
        end else begin
          state_next = S_TRACK;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending entry at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      cur_note_reg     <= REST_NOTE;
      len_reg          <= '0;
      stop_pending_reg <= 1'b0;
      wr_en_reg        <= 1'b0;
      wr_addr_reg      <= '0;
      wr_data_reg      <= '0;
      rec_count_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      cur_note_reg     <= cur_note_next;
      len_reg          <= len_next;
      stop_pending_reg <= stop_pending_next;
      wr_en_reg        <= wr_en_next;
      wr_addr_reg      <= wr_addr_next;
      wr_data_reg      <= wr_data_next;
      rec_count_reg    <= rec_count_next;
    end
  end

  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign rec_count   = rec_count_reg;
  assign busy        = (state_reg == S_ARMED) || (state_reg == S_TRACK) ||
                       (state_reg == S_WRITE);
  assign Done_record = (state_reg == S_DONE);

endmodule
